seq_divider: RTL and testbench

- Parametrised multi-cycle integer divider. Successor to the fixed 8-bit free-running divider.
- Adds a start/done handshake, selectable signed or unsigned mode, divide-by-zero and overflow flags, and held results.
- Radix-2 restoring algorithm: one quotient bit per clock. Sits between datapath control and any unit needing Q = A / B and R = A % B.

---
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring integer divider with a start/done
// handshake, signed or unsigned operands, and divide-by-zero / overflow flags.
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_a;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_trial;
  logic             w_b_zero;
  logic             w_ovf_case;

  // Two's-complement negate.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Conditional negate: magnitude on the way in, sign correction on the way out.
  function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? f_neg(v) : v;
  endfunction

  assign w_a_neg    = signed_mode & A[WIDTH-1];
  assign w_b_neg    = signed_mode & B[WIDTH-1];
  assign w_a_mag    = f_cond_neg(A, w_a_neg);
  assign w_b_mag    = f_cond_neg(B, w_b_neg);
  assign w_b_zero   = (B == '0);
  assign w_ovf_case = signed_mode && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

  // Partial remainder shifted left with the next dividend bit; the trial is a
  // WIDTH+1-bit compare against the divisor magnitude, and when it fits the
  // difference is always below the divisor so WIDTH bits hold it.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_dvsr});
  assign w_trial = w_shift[WIDTH-1:0] - r_dvsr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. Divide-by-zero takes a single idle pass through RUN
  // (counter preset to 1, datapath frozen) so its done lands two edges after accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_RUN;
      S_RUN:    if (r_cnt == CNT_W'(1)) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration, and result/flag registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_quo       <= w_a_mag;
            r_rem       <= '0;
            r_dvsr      <= w_b_mag;
            r_a         <= A;
            r_neg_q     <= w_a_neg ^ w_b_neg;
            r_neg_r     <= w_a_neg;
            r_dbz       <= w_b_zero;
            r_ovf       <= w_ovf_case;
            r_cnt       <= w_b_zero ? CNT_W'(1) : CNT_W'(WIDTH);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (!r_dbz) begin
            r_rem <= w_fits ? w_trial : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
          end
        end
        S_FINISH: begin
          if (r_dbz) begin
            Q <= '1;
            R <= r_a;
          end else begin
            Q <= f_cond_neg(r_quo, r_neg_q);
            R <= f_cond_neg(r_rem, r_neg_r);
          end
          div_by_zero <= r_dbz;
          overflow    <= r_ovf;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=8, plus a reference-model sweep at
// WIDTH=4 and WIDTH=16.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel    = 8;

  logic        st4, st8, st16, sm;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic        busy4, done4, dz4, ov4;
  logic        busy8, done8, dz8, ov8;
  logic        busy16, done16, dz16, ov16;
  logic [3:0]  q4, r4;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;

  seq_divider #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .signed_mode(sm), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .Q(q4), .R(r4), .div_by_zero(dz4), .overflow(ov4));

  seq_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Q(q8), .R(r8), .div_by_zero(dz8), .overflow(ov8));

  seq_divider #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(sm), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .Q(q16), .R(r16), .div_by_zero(dz16), .overflow(ov16));

  // Outputs of whichever instance is under test.
  logic        d_busy, d_done, d_dz, d_ov;
  logic [15:0] d_q, d_r;
  always_comb begin
    d_busy = busy8; d_done = done8; d_dz = dz8; d_ov = ov8;
    d_q = {8'h00, q8}; d_r = {8'h00, r8};
    if (sel == 4) begin
      d_busy = busy4; d_done = done4; d_dz = dz4; d_ov = ov4;
      d_q = {12'h000, q4}; d_r = {12'h000, r4};
    end else if (sel == 16) begin
      d_busy = busy16; d_done = done16; d_dz = dz16; d_ov = ov16;
      d_q = q16; d_r = r16;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands at the falling edge, let the next rising edge accept,
  // and return 1 ns after that edge. With hold=1 start stays high.
  task automatic go(input int w, input logic [15:0] a, input logic [15:0] b,
                    input logic s, input bit hold);
    @(negedge clk);
    sel = w; sm = s;
    a4 = a[3:0]; b4 = b[3:0]; a8 = a[7:0]; b8 = b[7:0]; a16 = a; b16 = b;
    st4 = (w == 4); st8 = (w == 8); st16 = (w == 16);
    @(posedge clk); #1;
    if (!hold) begin st4 = 0; st8 = 0; st16 = 0; end
  endtask

  // Edges from the current position until done is seen (bounded), and the
  // number of sampled cycles with busy high before done.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!d_done && lat < 100) begin
      if (d_busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Reference: native signed/unsigned division on wide integers.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic s, output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov);
    longint mask, ua, ub, sa, sb;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask; ub = longint'(b) & mask;
    sa = ua; sb = ub;
    if (s && ua[w-1]) sa = ua - (longint'(1) << w);
    if (s && ub[w-1]) sb = ub - (longint'(1) << w);
    dz = (ub == 0);
    ov = s && (sa == -(longint'(1) << (w-1))) && (sb == -1);
    if (dz) begin
      q = 16'(mask); r = 16'(ua);
    end else if (ov) begin
      q = 16'(ua); r = 16'h0000;
    end else begin
      q = 16'((sa / sb) & mask); r = 16'((sa % sb) & mask);
    end
  endtask

  int lat, bcnt, cnt, w;
  logic [15:0] ra, rb, eq, er;
  logic es, edz, eov;

  initial begin
    st4 = 0; st8 = 0; st16 = 0; sm = 0;
    a4 = 0; b4 = 0; a8 = 0; b8 = 0; a16 = 0; b16 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", d_busy, 0); chk("rst_done", d_done, 0);
    chk("rst_q", d_q, 0);       chk("rst_r", d_r, 0);
    chk("rst_dz", d_dz, 0);     chk("rst_ov", d_ov, 0);

    // 14 / 3 unsigned
    go(8, 14, 3, 0, 0);
    chk("u14_busy_accept", d_busy, 1);
    wait_done(lat, bcnt);
    chk("u14_lat", lat, 9); chk("u14_busycycles", bcnt, 9);
    chk("u14_q", d_q, 4);   chk("u14_r", d_r, 2);
    chk("u14_dz", d_dz, 0); chk("u14_ov", d_ov, 0);
    chk("u14_busy_done", d_busy, 0);
    @(posedge clk); #1;
    chk("u14_done_pulse", d_done, 0); chk("u14_q_hold", d_q, 4);

    // Back-to-back: 100/12 then 24/3, start held through the done cycle.
    // Operands change right after the first accept and must not disturb it.
    go(8, 100, 12, 0, 1);
    a8 = 24; b8 = 3;
    wait_done(lat, bcnt);
    chk("b2b1_lat", lat, 9); chk("b2b1_q", d_q, 8); chk("b2b1_r", d_r, 4);
    @(posedge clk); #1;
    st8 = 0;
    chk("b2b2_busy", d_busy, 1);
    wait_done(lat, bcnt);
    chk("b2b2_lat", lat, 9); chk("b2b2_q", d_q, 8); chk("b2b2_r", d_r, 0);

    // Signed
    go(8, 16'h00F2, 3, 1, 0);
    wait_done(lat, bcnt);
    chk("s_m14_q", d_q, 8'hFC); chk("s_m14_r", d_r, 8'hFE);
    go(8, 14, 16'h00FD, 1, 0);
    wait_done(lat, bcnt);
    chk("s_14m3_q", d_q, 8'hFC); chk("s_14m3_r", d_r, 2);

    // Divide by zero, then a normal op clears the flag
    go(8, 24, 0, 0, 0);
    wait_done(lat, bcnt);
    chk("dz_lat", lat, 2); chk("dz_q", d_q, 8'hFF); chk("dz_r", d_r, 24);
    chk("dz_flag", d_dz, 1);
    go(8, 8, 4, 0, 0);
    chk("dz_clr_accept", d_dz, 0);
    wait_done(lat, bcnt);
    chk("dz_next_q", d_q, 2); chk("dz_next_r", d_r, 0); chk("dz_next_flag", d_dz, 0);

    // Overflow, then the same operands unsigned
    go(8, 16'h0080, 16'h00FF, 1, 0);
    wait_done(lat, bcnt);
    chk("ov_q", d_q, 8'h80); chk("ov_r", d_r, 0); chk("ov_flag", d_ov, 1);
    go(8, 16'h0080, 16'h00FF, 0, 0);
    wait_done(lat, bcnt);
    chk("ovu_q", d_q, 0); chk("ovu_r", d_r, 8'h80); chk("ovu_flag", d_ov, 0);

    // Start while busy is ignored: 200/7 = 28 r 4
    go(8, 200, 7, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); st8 = 1; a8 = 9; b8 = 9;
    @(posedge clk); #1; st8 = 0;
    wait_done(lat, bcnt);
    chk("ign_q", d_q, 28); chk("ign_r", d_r, 4);
    cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (d_done) cnt++; end
    chk("ign_no_extra_done", cnt, 0); chk("ign_q_hold", d_q, 28);

    // Reset at E0+4 aborts the operation
    go(8, 50, 5, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("abort_busy", d_busy, 0); chk("abort_done", d_done, 0);
    chk("abort_q", d_q, 0);       chk("abort_r", d_r, 0);
    chk("abort_dz", d_dz, 0);     chk("abort_ov", d_ov, 0);
    cnt = 0;
    repeat (15) begin @(posedge clk); #1; if (d_done) cnt++; end
    chk("abort_no_done", cnt, 0);

    // Sweep over WIDTH=4 and WIDTH=16 against the reference model
    for (int i = 0; i < 40; i++) begin
      w  = (i % 2) ? 16 : 4;
      es = 1'($urandom_range(1, 0));
      ra = 16'($urandom); rb = 16'($urandom);
      if (i % 7 == 0) rb = 16'h0000;
      if (i % 9 == 3) begin
        es = 1'b1;
        ra = 16'(longint'(1) << (w-1));
        rb = 16'hFFFF;
      end
      if (w == 4) begin ra = ra & 16'h000F; rb = rb & 16'h000F; end
      model(w, ra, rb, es, eq, er, edz, eov);
      go(w, ra, rb, es, 0);
      wait_done(lat, bcnt);
      chk($sformatf("sw%0d_w%0d_lat", i, w), lat, edz ? 2 : w + 1);
      chk($sformatf("sw%0d_w%0d_q a=%0h b=%0h s=%0d", i, w, ra, rb, es), d_q, eq);
      chk($sformatf("sw%0d_w%0d_r", i, w), d_r, er);
      chk($sformatf("sw%0d_w%0d_dz", i, w), d_dz, edz);
      chk($sformatf("sw%0d_w%0d_ov", i, w), d_ov, eov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
